// File: rtl/adder_sum_accumulator.sv
// ---------------------------------------------------------------------------
// adder_sum_accumulator
//
// Purpose:
//   This block sits after the 8-bit gate-level adder. It adds up FRAME_LEN
//   adder results {carry, out[7:0]} into one saturating frame sum. It also
//   counts how many of those results had the carry bit set. The finished
//   frame is offered downstream on a valid/ready handshake. While a finished
//   frame waits to be accepted, in_ready stays low and the adder-side feed
//   is stalled.
//
// Parameters:
//   FRAME_LEN  number of adder results per frame (>= 1)
//   ACC_W      width of the accumulated frame sum (>= 9)
//   CNT_W      width of the sample and carry counters (2**CNT_W > FRAME_LEN)
//
// Ports:
//   clk        system clock; all state updates on the rising edge
//   rst        asynchronous, active-high reset; discards any partial frame
//   in_valid   in_sum carries a result this cycle
//   in_ready   block can take in_sum this cycle (registered, state-decoded)
//   in_sum     adder result {carry, out[7:0]}, unsigned
//   out_valid  frame result is valid
//   out_ready  downstream accepts the frame result
//   frame_sum  saturated sum of the frame (running value while accumulating)
//   carry_cnt  number of results in the frame with in_sum[8] set
//   sat        frame_sum clipped at its maximum during this frame
// ---------------------------------------------------------------------------
module adder_sum_accumulator #(
   parameter int FRAME_LEN = 10,
   parameter int ACC_W     = 16,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [8:0]       in_sum,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] frame_sum,
   output logic [CNT_W-1:0] carry_cnt,
   output logic             sat
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [ACC_W-1:0] ACC_MAX   = {ACC_W{1'b1}};
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_LEN);
   localparam bit               ONE_SHOT  = (FRAME_LEN == 1);

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] sample_cnt;
   logic [CNT_W-1:0] carry_q;
   logic             sat_q;
   logic             in_ready_q;
   logic             out_valid_q;

   // The sum is one bit wider than the accumulator, so bit ACC_W is the
   // overflow flag used for saturation.
   logic [ACC_W:0]   acc_wide;
   logic             acc_ovf;
   logic [ACC_W-1:0] acc_next;
   logic [CNT_W-1:0] sample_next;
   logic             xfer;

   // NOTE: in_sum only reaches state through terms that a transfer gates.
   // An X on in_sum while in_valid is low therefore cannot reach any
   // register.
   assign xfer        = in_valid & in_ready_q;
   assign acc_wide    = {1'b0, acc} + (ACC_W + 1)'(in_sum);
   assign acc_ovf     = acc_wide[ACC_W];
   assign acc_next    = acc_ovf ? ACC_MAX : acc_wide[ACC_W-1:0];
   assign sample_next = sample_cnt + 1'b1;

   // NOTE: every register in this always_ff uses non-blocking assignments.
   // All flops then see the values from before the edge. This matters where
   // state, counters and the handshake flags depend on each other.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         acc         <= '0;
         sample_cnt  <= '0;
         carry_q     <= '0;
         sat_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (xfer) begin
                  // First sample loads the accumulator directly. A 9-bit
                  // value always fits because ACC_W >= 9.
                  acc        <= ACC_W'(in_sum);
                  sample_cnt <= CNT_W'(1);
                  carry_q    <= CNT_W'(in_sum[8]);
                  if (ONE_SHOT) begin
                     state       <= DONE;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end

            ACCUM: begin
               // in_valid low is a bubble: nothing changes.
               if (xfer) begin
                  acc        <= acc_next;
                  sat_q      <= sat_q | acc_ovf;
                  sample_cnt <= sample_next;
                  carry_q    <= carry_q + CNT_W'(in_sum[8]);
                  if (sample_next == LAST_CNT) begin
                     state       <= DONE;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                  end
               end
            end

            DONE: begin
               // The frame result is frozen until downstream takes it.
               // in_valid is ignored here because in_ready is low.
               if (out_ready) begin
                  state       <= IDLE;
                  acc         <= '0;
                  sample_cnt  <= '0;
                  carry_q     <= '0;
                  sat_q       <= 1'b0;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
               end
            end

            default: begin
               state       <= IDLE;
               acc         <= '0;
               sample_cnt  <= '0;
               carry_q     <= '0;
               sat_q       <= 1'b0;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign frame_sum = acc;
   assign carry_cnt = carry_q;
   assign sat       = sat_q;

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// ---------------------------------------------------------------------------
// tb_adder_sum_accumulator
//
// Purpose:
//   Directed, self-checking bench for adder_sum_accumulator. It uses three
//   instances:
//     a : FRAME_LEN=10, ACC_W=16 (reset, nominal, backpressure, bubbles)
//     b : FRAME_LEN=3,  ACC_W=9  (saturation)
//     c : FRAME_LEN=1,  ACC_W=16 (single-sample frames)
//   Inputs change and outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_adder_sum_accumulator;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- instance a ----------------
   logic        a_in_valid = 1'b0, a_out_ready = 1'b0;
   logic [8:0]  a_in_sum   = '0;
   logic        a_in_ready, a_out_valid, a_sat;
   logic [15:0] a_frame_sum;
   logic [7:0]  a_carry_cnt;

   adder_sum_accumulator #(.FRAME_LEN(10), .ACC_W(16), .CNT_W(8)) u_a (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sum(a_in_sum),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .frame_sum(a_frame_sum), .carry_cnt(a_carry_cnt), .sat(a_sat)
   );

   // ---------------- instance b ----------------
   logic        b_in_valid = 1'b0, b_out_ready = 1'b0;
   logic [8:0]  b_in_sum   = '0;
   logic        b_in_ready, b_out_valid, b_sat;
   logic [8:0]  b_frame_sum;
   logic [7:0]  b_carry_cnt;

   adder_sum_accumulator #(.FRAME_LEN(3), .ACC_W(9), .CNT_W(8)) u_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sum(b_in_sum),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .frame_sum(b_frame_sum), .carry_cnt(b_carry_cnt), .sat(b_sat)
   );

   // ---------------- instance c ----------------
   logic        c_in_valid = 1'b0, c_out_ready = 1'b0;
   logic [8:0]  c_in_sum   = '0;
   logic        c_in_ready, c_out_valid, c_sat;
   logic [15:0] c_frame_sum;
   logic [7:0]  c_carry_cnt;

   adder_sum_accumulator #(.FRAME_LEN(1), .ACC_W(16), .CNT_W(8)) u_c (
      .clk(clk), .rst(rst),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .in_sum(c_in_sum),
      .out_valid(c_out_valid), .out_ready(c_out_ready),
      .frame_sum(c_frame_sum), .carry_cnt(c_carry_cnt), .sat(c_sat)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_a(input logic [8:0] v);
      a_in_valid = 1'b1;
      a_in_sum   = v;
      tick();
      a_in_valid = 1'b0;
      a_in_sum   = 'x;
   endtask

   task automatic push_b(input logic [8:0] v);
      b_in_valid = 1'b1;
      b_in_sum   = v;
      tick();
      b_in_valid = 1'b0;
      b_in_sum   = 'x;
   endtask

   task automatic accept_a();
      a_out_ready = 1'b1;
      tick();
      a_out_ready = 1'b0;
   endtask

   task automatic accept_b();
      b_out_ready = 1'b1;
      tick();
      b_out_ready = 1'b0;
   endtask

   // Operand pairs for the 8-bit adder. The results are {carry, out}.
   logic [7:0] px [10] = '{8'hFF, 8'h80, 8'h00, 8'h12, 8'h7F,
                           8'h0F, 8'h55, 8'h01, 8'hC8, 8'h64};
   logic [7:0] py [10] = '{8'h01, 8'h80, 8'h00, 8'h34, 8'h7F,
                           8'hF0, 8'hAA, 8'h02, 8'h37, 8'h32};

   initial begin
      logic [8:0] r;
      int         c_valid_cnt;

      // ---------------- reset state ----------------
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(a_out_valid), 32'd0);
      check("rst_in_ready",  32'(a_in_ready),  32'd1);
      check("rst_frame_sum", 32'(a_frame_sum), 32'd0);
      check("rst_carry_cnt", 32'(a_carry_cnt), 32'd0);
      check("rst_sat",       32'(a_sat),       32'd0);
      rst = 1'b0;
      tick();

      // ---------------- reset mid-frame ----------------
      for (int i = 0; i < 4; i++) push_a(9'h0FF);
      check("mid_running_sum", 32'(a_frame_sum), 32'h3FC);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_sum",      32'(a_frame_sum), 32'd0);
      check("mid_rst_in_ready", 32'(a_in_ready),  32'd1);
      tick();
      for (int i = 0; i < 9; i++) push_a(9'h001);
      check("mid_not_done_9", 32'(a_out_valid), 32'd0);
      push_a(9'h001);
      check("mid_out_valid", 32'(a_out_valid), 32'd1);
      check("mid_frame_sum", 32'(a_frame_sum), 32'd10);
      check("mid_carry_cnt", 32'(a_carry_cnt), 32'd0);
      check("mid_sat",       32'(a_sat),       32'd0);
      accept_a();
      check("mid_acc_valid",    32'(a_out_valid), 32'd0);
      check("mid_acc_in_ready", 32'(a_in_ready),  32'd1);

      // ---------------- nominal frame from adder results ----------------
      for (int i = 0; i < 10; i++) begin
         r = {1'b0, px[i]} + {1'b0, py[i]};
         push_a(r);
      end
      check("nom_out_valid", 32'(a_out_valid), 32'd1);
      check("nom_frame_sum", 32'(a_frame_sum), 32'd1754);
      check("nom_carry_cnt", 32'(a_carry_cnt), 32'd2);
      check("nom_sat",       32'(a_sat),       32'd0);

      // ---------------- backpressure ----------------
      a_in_valid = 1'b1;
      a_in_sum   = 9'h1FF;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_in_ready",  32'(a_in_ready),  32'd0);
         check("bp_out_valid", 32'(a_out_valid), 32'd1);
         check("bp_frame_sum", 32'(a_frame_sum), 32'd1754);
         check("bp_carry_cnt", 32'(a_carry_cnt), 32'd2);
      end
      a_in_valid = 1'b0;
      a_in_sum   = 'x;
      accept_a();
      check("bp_acc_valid",    32'(a_out_valid), 32'd0);
      check("bp_acc_in_ready", 32'(a_in_ready),  32'd1);
      check("bp_acc_sum",      32'(a_frame_sum), 32'd0);
      check("bp_acc_carry",    32'(a_carry_cnt), 32'd0);

      // ---------------- bubbles ----------------
      for (int i = 0; i < 19; i++) begin
         a_in_valid = (i % 2 == 0);
         a_in_sum   = (i % 2 == 0) ? 9'h100 : 9'bx;
         tick();
         if (i == 16) check("bub_not_done_9", 32'(a_out_valid), 32'd0);
      end
      a_in_valid = 1'b0;
      a_in_sum   = 'x;
      check("bub_out_valid", 32'(a_out_valid), 32'd1);
      check("bub_frame_sum", 32'(a_frame_sum), 32'h0A00);
      check("bub_carry_cnt", 32'(a_carry_cnt), 32'd10);
      accept_a();

      // ---------------- saturation ----------------
      push_b(9'h1FF);
      push_b(9'h001);
      check("sat_mid_sat", 32'(b_sat),       32'd1);
      check("sat_mid_sum", 32'(b_frame_sum), 32'h1FF);
      push_b(9'h010);
      check("sat_out_valid", 32'(b_out_valid), 32'd1);
      check("sat_frame_sum", 32'(b_frame_sum), 32'h1FF);
      check("sat_flag",      32'(b_sat),       32'd1);
      check("sat_carry_cnt", 32'(b_carry_cnt), 32'd1);
      accept_b();
      check("sat_cleared", 32'(b_sat), 32'd0);
      push_b(9'h001);
      push_b(9'h002);
      push_b(9'h003);
      check("sat2_frame_sum", 32'(b_frame_sum), 32'd6);
      check("sat2_flag",      32'(b_sat),       32'd0);
      check("sat2_carry_cnt", 32'(b_carry_cnt), 32'd0);
      accept_b();

      // ---------------- FRAME_LEN = 1 ----------------
      c_in_valid = 1'b1;
      c_in_sum   = 9'h155;
      tick();
      c_in_valid = 1'b0;
      c_in_sum   = 'x;
      check("one_out_valid", 32'(c_out_valid), 32'd1);
      check("one_frame_sum", 32'(c_frame_sum), 32'h155);
      check("one_carry_cnt", 32'(c_carry_cnt), 32'd1);
      check("one_in_ready",  32'(c_in_ready),  32'd0);
      c_out_ready = 1'b1;
      tick();
      check("one_acc_valid", 32'(c_out_valid), 32'd0);
      // Continuous flow: valid alternates 1,0,1,0,...
      c_in_valid  = 1'b1;
      c_in_sum    = 9'h0AA;
      c_valid_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("one_stream_valid", 32'(c_out_valid), (i % 2 == 0) ? 32'd1 : 32'd0);
         if (c_out_valid) begin
            c_valid_cnt++;
            check("one_stream_sum", 32'(c_frame_sum), 32'h0AA);
         end
      end
      check("one_stream_count", 32'(c_valid_cnt), 32'd3);
      c_in_valid  = 1'b0;
      c_out_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
